ew_gray_sync_mc: RTL

- Multi-channel, parametrised Gray-code pointer synchroniser for async FIFO pointer crossing, in the destination clock domain.
- Per channel: a SYNC-stage flop chain, then a registered output stage.
- The output stage provides the synchronised Gray value, its binary decode, a one-cycle change strobe, and a sticky error flag. The flag sets when the synchronised value moves by more than one bit, which is a Gray-discipline violation.

---
 rtl/ew_gray_sync_mc.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ew_gray_sync_mc.sv
// ew_gray_sync_mc
//   Multi-channel Gray-code pointer synchroniser for async FIFO pointer
//   crossing. Each channel runs its input through a C_SYNC-deep flop chain
//   (C_SYNC = max(SYNC,2)) and then a registered output stage. The output
//   stage presents the Gray value, its binary decode, a one-cycle change
//   strobe and a sticky flag that marks any update moving more than one bit.
//
//   Optional feature macro: EW_GRAY_ERR_CNT_EN adds a saturating per-channel
//   error-event counter exported on err_cnt_o.
//
// Ports
//   clk        destination-domain clock (posedge)
//   rst_n      synchronous active-low reset
//   init_n     synchronous active-low soft init (same clear, lower priority)
//   test       1 = output stage samples data_i directly (chain bypass)
//   data_i     CHANNELS*DATA_WIDTH async Gray inputs
//   err_clr_i  per-channel clear of the sticky error flag
//   gray_o     synchronised Gray value per channel
//   bin_o      binary decode of gray_o, registered alongside it
//   chg_o      one-cycle pulse when a channel's output value changed
//   err_o      sticky multi-bit-change flag per channel
//   err_cnt_o  per-channel error count (EW_GRAY_ERR_CNT_EN only)

module ew_gray_sync_mc #(
  parameter int DATA_WIDTH = 4,
  parameter int CHANNELS   = 1,
  parameter int SYNC       = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init_n,
  input  logic                           test,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
  input  logic [CHANNELS-1:0]            err_clr_i,
  output logic [CHANNELS*DATA_WIDTH-1:0] gray_o,
  output logic [CHANNELS*DATA_WIDTH-1:0] bin_o,
  output logic [CHANNELS-1:0]            chg_o,
  output logic [CHANNELS-1:0]            err_o
`ifdef EW_GRAY_ERR_CNT_EN
  ,
  output logic [CHANNELS*ERR_CNT_W-1:0]  err_cnt_o
`endif
);

  // Depths below two give no metastability protection, so they are raised.
  localparam int C_SYNC = (SYNC < 2) ? 2 : SYNC;

  // Both reset sources clear the same state; rst_n dominance is implicit.
  logic clear;
  assign clear = !rst_n || !init_n;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] sync_reg [C_SYNC];
      logic [DATA_WIDTH-1:0] gray_reg;
      logic [DATA_WIDTH-1:0] bin_reg;
      logic                  chg_reg;
      logic                  err_reg;
      logic [DATA_WIDTH-1:0] new_val;
      logic [DATA_WIDTH-1:0] diff;
      logic [DATA_WIDTH-1:0] bin_next;
      logic                  multi_bit;

      assign new_val = test ? data_i[gi*DATA_WIDTH +: DATA_WIDTH]
                            : sync_reg[C_SYNC-1];
      assign diff    = new_val ^ gray_reg;
      // Clearing the lowest set bit leaves something only if >1 bit differs.
      assign multi_bit = |(diff & (diff - DATA_WIDTH'(1)));

      // Binary bit i is the XOR of all Gray bits at or above i.
      always_comb begin
        bin_next = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
          bin_next[i] = ^(new_val >> i);
        end
      end

      // The chain shifts in both modes so returning from bypass is clean.
      always_ff @(posedge clk) begin
        if (clear) begin
          for (int k = 0; k < C_SYNC; k++) begin
            sync_reg[k] <= '0;
          end
          gray_reg <= '0;
          bin_reg  <= '0;
          chg_reg  <= 1'b0;
          err_reg  <= 1'b0;
        end else begin
          sync_reg[0] <= data_i[gi*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < C_SYNC; k++) begin
            sync_reg[k] <= sync_reg[k-1];
          end
          gray_reg <= new_val;
          bin_reg  <= bin_next;
          chg_reg  <= (diff != '0);
          // A new violation outranks a same-cycle clear.
          err_reg  <= multi_bit || (err_reg && !err_clr_i[gi]);
        end
      end

      assign gray_o[gi*DATA_WIDTH +: DATA_WIDTH] = gray_reg;
      assign bin_o[gi*DATA_WIDTH +: DATA_WIDTH]  = bin_reg;
      assign chg_o[gi] = chg_reg;
      assign err_o[gi] = err_reg;

`ifdef EW_GRAY_ERR_CNT_EN
      logic [ERR_CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (clear) begin
          cnt_reg <= '0;
        end else if (multi_bit) begin
          // A clear in the same cycle as an event restarts the count at one.
          if (err_clr_i[gi]) begin
            cnt_reg <= ERR_CNT_W'(1);
          end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + ERR_CNT_W'(1);
          end
        end else if (err_clr_i[gi]) begin
          cnt_reg <= '0;
        end
      end

      assign err_cnt_o[gi*ERR_CNT_W +: ERR_CNT_W] = cnt_reg;
`endif
    end
  endgenerate

endmodule
